// File: rtl/instr_loader_if.sv
// Byte-stream and instruction-memory bus for instr_loader.
// master = loader side, slave = byte source / memory / control side.
interface instr_loader_if;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        write_en;
  logic [15:0] addr;
  logic [15:0] instr_in;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  modport master (
    input  start, byte_in, byte_valid,
    output byte_ready, write_en, addr, instr_in, busy, done, error, cpu_hold
  );

  modport slave (
    output start, byte_in, byte_valid,
    input  byte_ready, write_en, addr, instr_in, busy, done, error, cpu_hold
  );
endinterface

// File: rtl/instr_loader.sv
// Streams a counted program image (count lo/hi, then words lo-first) into instruction memory.
// Optional trailing modulo-256 data checksum is enabled by defining LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int unsigned DEPTH     = 181,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic           clk,
  input  logic           rst,
  instr_loader_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_DAT_LO,
    S_DAT_HI,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [15:0] BASE_W  = 16'(BASE_ADDR);

  state_t      r_state;
  logic [15:0] r_count;
  logic [15:0] r_index;
  logic [7:0]  r_lo;
  logic        r_write_en;
  logic [15:0] r_addr;
  logic [15:0] r_instr;
  logic        r_done;
  logic        r_error;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_checksum;
`endif

  logic        w_byte_ready;
  logic        w_busy;
  logic        w_xfer;
  logic [15:0] w_count_full;
  logic        w_last_word;

  always_comb begin
    w_byte_ready = 1'b0;
    case (r_state)
      S_CNT_LO, S_CNT_HI, S_DAT_LO, S_DAT_HI: w_byte_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:                                w_byte_ready = 1'b1;
`endif
      default:                                w_byte_ready = 1'b0;
    endcase
  end

  assign w_busy       = !(r_state inside {S_IDLE, S_DONE, S_ERROR});
  assign w_xfer       = bus.byte_valid && w_byte_ready;
  assign w_count_full = {bus.byte_in, r_count[7:0]};
  assign w_last_word  = (r_index + 16'd1) == r_count;

  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_index    <= '0;
      r_lo       <= '0;
      r_write_en <= 1'b0;
      r_addr     <= '0;
      r_instr    <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_checksum <= '0;
`endif
    end else begin
      r_write_en <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.start) begin
            r_state <= S_CNT_LO;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_index <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_checksum <= '0;
`endif
          end
        end
        S_CNT_LO: begin
          if (w_xfer) begin
            r_count[7:0] <= bus.byte_in;
            r_state      <= S_CNT_HI;
          end
        end
        S_CNT_HI: begin
          if (w_xfer) begin
            r_count <= w_count_full;
            if (w_count_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              r_state <= S_CHECK;
`else
              r_state <= S_DONE;
              r_done  <= 1'b1;
`endif
            end else if ({16'd0, w_count_full} > DEPTH_W) begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end else begin
              r_state <= S_DAT_LO;
            end
          end
        end
        S_DAT_LO: begin
          if (w_xfer) begin
            r_lo    <= bus.byte_in;
            r_state <= S_DAT_HI;
`ifdef LOADER_CHECKSUM_EN
            r_checksum <= r_checksum + bus.byte_in;
`endif
          end
        end
        S_DAT_HI: begin
          // The strobe, address and data are registered here so they are valid throughout WRITE.
          if (w_xfer) begin
            r_write_en <= 1'b1;
            r_addr     <= BASE_W + r_index;
            r_instr    <= {bus.byte_in, r_lo};
            r_state    <= S_WRITE;
`ifdef LOADER_CHECKSUM_EN
            r_checksum <= r_checksum + bus.byte_in;
`endif
          end
        end
        S_WRITE: begin
          r_index <= r_index + 16'd1;
          if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
            r_state <= S_CHECK;
`else
            r_state <= S_DONE;
            r_done  <= 1'b1;
`endif
          end else begin
            r_state <= S_DAT_LO;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (w_xfer) begin
            if (bus.byte_in == r_checksum) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.byte_ready = w_byte_ready;
  assign bus.write_en   = r_write_en;
  assign bus.addr       = r_addr;
  assign bus.instr_in   = r_instr;
  assign bus.busy       = w_busy;
  assign bus.done       = r_done;
  assign bus.error      = r_error;
  assign bus.cpu_hold   = !r_done;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: byte streams driven on negedge, memory writes captured on negedge.
// Checksum scenarios are compiled in when LOADER_CHECKSUM_EN is defined.
module tb_instr_loader;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst;

  instr_loader_if bus();

  instr_loader #(.DEPTH(181), .BASE_ADDR(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;

  logic [15:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int          wr_time_q[$];

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (bus.write_en === 1'b1) begin
      wr_addr_q.push_back(bus.addr);
      wr_data_q.push_back(bus.instr_in);
      wr_time_q.push_back(cycle);
    end
  end

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_time_q.delete();
  endtask

  // Present one byte and hold it until a transfer; returns at the negedge after the transfer.
  task automatic present(input logic [7:0] b, input int max_gap);
    int gap;
    int waited;
    gap    = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    waited = 0;
    if (gap > 0) begin
      bus.byte_valid = 1'b0;
      bus.byte_in    = ~b;
      repeat (gap) @(negedge clk);
    end
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (bus.byte_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      n_checks++;
      $display("FAIL send_timeout byte=%02h byte_ready never rose", b);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic send_stream(input byte_q_t s, input int max_gap);
    foreach (s[i]) present(s[i], max_gap);
    bus.byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!(bus.done === 1'b1 || bus.error === 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      $display("FAIL %s_timeout neither done nor error after 50 cycles", name);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    #12;
    n_checks++;
    if ({bus.write_en, bus.addr, bus.instr_in, bus.byte_ready, bus.busy, bus.done, bus.error, bus.cpu_hold}
        !== {1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_outputs got we=%b addr=%h instr=%h rdy=%b busy=%b done=%b err=%b hold=%b exp 0/0000/0000/0/0/0/0/1",
               bus.write_en, bus.addr, bus.instr_in, bus.byte_ready, bus.busy, bus.done, bus.error, bus.cpu_hold);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.byte_ready, bus.cpu_hold} !== 3'b001)
      $display("FAIL reset_idle got busy=%b rdy=%b hold=%b exp 0/0/1", bus.busy, bus.byte_ready, bus.cpu_hold);
    else n_pass++;
  endtask

  task automatic test_basic();
    byte_q_t s;
    clear_writes();
    pulse_start();
    n_checks++;
    if ({bus.busy, bus.byte_ready, bus.cpu_hold} !== 3'b111)
      $display("FAIL basic_busy got busy=%b rdy=%b hold=%b exp 1/1/1", bus.busy, bus.byte_ready, bus.cpu_hold);
    else n_pass++;
    s = {8'h02, 8'h00, 8'h26, 8'h00, 8'h01, 8'h01};
`ifdef LOADER_CHECKSUM_EN
    s.push_back(8'h28);
`endif
    send_stream(s, 0);
    wait_end("basic");
    n_checks++;
    if (wr_addr_q.size() !== 2)
      $display("FAIL basic_nwrites got=%0d exp=2", wr_addr_q.size());
    else n_pass++;
    n_checks++;
    if (wr_addr_q.size() < 2 || wr_addr_q[0] !== 16'h0000 || wr_data_q[0] !== 16'h0026)
      $display("FAIL basic_word0 got addr=%h data=%h exp addr=0000 data=0026",
               wr_addr_q.size() > 0 ? wr_addr_q[0] : 16'hxxxx, wr_data_q.size() > 0 ? wr_data_q[0] : 16'hxxxx);
    else n_pass++;
    n_checks++;
    if (wr_addr_q.size() < 2 || wr_addr_q[1] !== 16'h0001 || wr_data_q[1] !== 16'h0101)
      $display("FAIL basic_word1 got addr=%h data=%h exp addr=0001 data=0101",
               wr_addr_q.size() > 1 ? wr_addr_q[1] : 16'hxxxx, wr_data_q.size() > 1 ? wr_data_q[1] : 16'hxxxx);
    else n_pass++;
    n_checks++;
    if ({bus.done, bus.error, bus.cpu_hold, bus.busy, bus.write_en} !== 5'b10000)
      $display("FAIL basic_flags got done=%b err=%b hold=%b busy=%b we=%b exp 1/0/0/0/0",
               bus.done, bus.error, bus.cpu_hold, bus.busy, bus.write_en);
    else n_pass++;
    n_checks++;
    if (bus.addr !== 16'h0001 || bus.instr_in !== 16'h0101)
      $display("FAIL basic_hold_bus got addr=%h instr=%h exp 0001/0101", bus.addr, bus.instr_in);
    else n_pass++;
  endtask

  task automatic test_full_depth();
    byte_q_t s;
    logic [7:0] sum;
    int bad;
    clear_writes();
    sum = 8'h00;
    s   = {8'hB5, 8'h00};
    for (int i = 0; i < 181; i++) begin
      s.push_back(8'(i));
      s.push_back(8'hA0 ^ 8'(i));
      sum = sum + 8'(i) + (8'hA0 ^ 8'(i));
    end
`ifdef LOADER_CHECKSUM_EN
    s.push_back(sum);
`endif
    pulse_start();
    send_stream(s, 0);
    wait_end("depth");
    n_checks++;
    if (wr_addr_q.size() !== 181)
      $display("FAIL depth_nwrites got=%0d exp=181", wr_addr_q.size());
    else n_pass++;
    bad = 0;
    for (int i = 0; i < wr_addr_q.size() && i < 181; i++)
      if (wr_addr_q[i] !== 16'(i) || wr_data_q[i] !== {8'hA0 ^ 8'(i), 8'(i)}) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL depth_words got %0d bad words exp 0", bad);
    else n_pass++;
    n_checks++;
    if (wr_addr_q.size() < 181 || wr_addr_q[180] !== 16'h00B4)
      $display("FAIL depth_last_addr got=%h exp=00b4", wr_addr_q.size() > 0 ? wr_addr_q[wr_addr_q.size()-1] : 16'hxxxx);
    else n_pass++;
    n_checks++;
    if (wr_time_q.size() < 2 || (wr_time_q[1] - wr_time_q[0]) != 3)
      $display("FAIL depth_word_spacing got=%0d cycles exp=3",
               wr_time_q.size() > 1 ? wr_time_q[1] - wr_time_q[0] : -1);
    else n_pass++;
    n_checks++;
    if ({bus.done, bus.error} !== 2'b10)
      $display("FAIL depth_done got done=%b err=%b exp 1/0", bus.done, bus.error);
    else n_pass++;

    clear_writes();
    pulse_start();
    send_stream({8'hB6, 8'h00}, 0);
    wait_end("overflow");
    repeat (4) @(negedge clk);
    n_checks++;
    if ({bus.done, bus.error, bus.busy, bus.cpu_hold} !== 4'b0101)
      $display("FAIL overflow_flags got done=%b err=%b busy=%b hold=%b exp 0/1/0/1",
               bus.done, bus.error, bus.busy, bus.cpu_hold);
    else n_pass++;
    n_checks++;
    if (wr_addr_q.size() !== 0)
      $display("FAIL overflow_nwrites got=%0d exp=0", wr_addr_q.size());
    else n_pass++;
  endtask

  task automatic test_random_valid();
    byte_q_t s;
    clear_writes();
    s = {8'h03, 8'h00, 8'hEF, 8'hBE, 8'h00, 8'h00, 8'hFF, 8'hFF};
`ifdef LOADER_CHECKSUM_EN
    s.push_back(8'hAB);
`endif
    pulse_start();
    send_stream(s, 3);
    wait_end("random");
    n_checks++;
    if (wr_addr_q.size() !== 3)
      $display("FAIL random_nwrites got=%0d exp=3", wr_addr_q.size());
    else n_pass++;
    n_checks++;
    if (wr_addr_q.size() != 3 ||
        wr_data_q[0] !== 16'hBEEF || wr_data_q[1] !== 16'h0000 || wr_data_q[2] !== 16'hFFFF ||
        wr_addr_q[0] !== 16'h0000 || wr_addr_q[1] !== 16'h0001 || wr_addr_q[2] !== 16'h0002)
      $display("FAIL random_words got first data=%h exp beef/0000/ffff at 0/1/2",
               wr_data_q.size() > 0 ? wr_data_q[0] : 16'hxxxx);
    else n_pass++;
    n_checks++;
    if (bus.done !== 1'b1) $display("FAIL random_done got=%b exp=1", bus.done);
    else n_pass++;
  endtask

  task automatic test_start_while_busy();
    byte_q_t s;
    clear_writes();
    pulse_start();
    send_stream({8'h01, 8'h00}, 0);
    pulse_start();
    s = {8'h34, 8'h12};
`ifdef LOADER_CHECKSUM_EN
    s.push_back(8'h46);
`endif
    send_stream(s, 0);
    wait_end("busy_start");
    n_checks++;
    if (wr_data_q.size() != 1 || wr_data_q[0] !== 16'h1234 || bus.done !== 1'b1)
      $display("FAIL busy_start got nwrites=%0d done=%b exp 1 write of 1234 and done=1",
               wr_data_q.size(), bus.done);
    else n_pass++;
  endtask

  task automatic test_zero_count();
    byte_q_t s;
    clear_writes();
    s = {8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    s.push_back(8'h00);
`endif
    pulse_start();
    send_stream(s, 0);
    wait_end("zero");
    n_checks++;
    if (wr_addr_q.size() !== 0 || {bus.done, bus.error, bus.cpu_hold} !== 3'b100)
      $display("FAIL zero_count got nwrites=%0d done=%b err=%b hold=%b exp 0/1/0/0",
               wr_addr_q.size(), bus.done, bus.error, bus.cpu_hold);
    else n_pass++;
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_writes();
    pulse_start();
    send_stream({8'h01, 8'h00, 8'hFE, 8'h00, 8'hFE}, 0);
    wait_end("csum_ok");
    n_checks++;
    if ({bus.done, bus.error} !== 2'b10 || wr_data_q.size() != 1 || wr_data_q[0] !== 16'h00FE)
      $display("FAIL csum_ok got done=%b err=%b nwrites=%0d exp 1/0/1", bus.done, bus.error, wr_data_q.size());
    else n_pass++;
    clear_writes();
    pulse_start();
    send_stream({8'h01, 8'h00, 8'hFE, 8'h00, 8'hFF}, 0);
    wait_end("csum_bad");
    n_checks++;
    if ({bus.done, bus.error, bus.cpu_hold} !== 3'b011 || wr_addr_q.size() != 1 || wr_addr_q[0] !== 16'h0000)
      $display("FAIL csum_bad got done=%b err=%b hold=%b nwrites=%0d exp 0/1/1/1",
               bus.done, bus.error, bus.cpu_hold, wr_addr_q.size());
    else n_pass++;
  endtask
`endif

  task automatic test_reset_midload();
    int n_before;
    clear_writes();
    pulse_start();
    send_stream({8'h04, 8'h00, 8'hAA, 8'h11}, 0);
    @(negedge clk);
    n_checks++;
    if (wr_data_q.size() != 1 || wr_data_q[0] !== 16'h11AA)
      $display("FAIL midload_word0 got nwrites=%0d exp 1 write of 11aa", wr_data_q.size());
    else n_pass++;
    present(8'h55, 0);
    bus.byte_in    = 8'h66;
    bus.byte_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.write_en, bus.addr, bus.instr_in, bus.byte_ready, bus.busy, bus.done, bus.error, bus.cpu_hold}
        !== {1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1})
      $display("FAIL midload_reset got we=%b addr=%h instr=%h rdy=%b busy=%b done=%b err=%b hold=%b exp 0/0000/0000/0/0/0/0/1",
               bus.write_en, bus.addr, bus.instr_in, bus.byte_ready, bus.busy, bus.done, bus.error, bus.cpu_hold);
    else n_pass++;
    n_before = wr_addr_q.size();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.byte_in = 8'(i * 7);
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
    n_checks++;
    if (wr_addr_q.size() != n_before || bus.busy !== 1'b0 || bus.cpu_hold !== 1'b1)
      $display("FAIL midload_no_writes got nwrites=%0d busy=%b hold=%b exp %0d/0/1",
               wr_addr_q.size(), bus.busy, bus.cpu_hold, n_before);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_depth();
    test_random_valid();
    test_start_while_busy();
    test_zero_count();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_midload();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter DEPTH, default 181: number of instruction-memory words; the highest legal word index is DEPTH-1.
REQ-002 Parameter BASE_ADDR, default 0: memory address of the first loaded word.
REQ-003 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port start, input, 1: one-cycle pulse that begins a load; ignored unless in IDLE, DONE or ERROR.
REQ-006 Port byte_in, input, 8: incoming program byte.
REQ-007 Port byte_valid, input, 1: byte_in is valid.
REQ-008 Port byte_ready, output, 1: loader accepts byte_in this cycle; a transfer occurs when byte_valid and byte_ready are both high.
REQ-009 Port write_en, output, 1: instruction-memory write strobe.
REQ-010 Port addr, output, 16: instruction-memory address.
REQ-011 Port instr_in, output, 16: instruction-memory write data.
REQ-012 Port busy, output, 1: high while a load is in progress.
REQ-013 Port done, output, 1: load completed successfully; held until the next start or reset.
REQ-014 Port error, output, 1: load aborted; held until the next start or reset.
REQ-015 Port cpu_hold, output, 1: keeps the processor stalled; high whenever done is low.

Function
REQ-016 Stream format: count low byte, count high byte (N = number of words), then N words, each sent low byte first.
REQ-017 States: IDLE, CNT_LO, CNT_HI, DAT_LO, DAT_HI, WRITE, CHECK, DONE, ERROR.
REQ-018 start moves the FSM to CNT_LO, clears done and error, and zeroes the word index and the checksum.
REQ-019 byte_ready is high only in CNT_LO, CNT_HI, DAT_LO, DAT_HI and CHECK; it is combinational from state.
REQ-020 CNT_HI exit: N=0 -> CHECK when LOADER_CHECKSUM_EN is defined, otherwise DONE; N>DEPTH -> ERROR; otherwise -> DAT_LO.
REQ-021 Accepting a byte in DAT_HI moves the FSM to WRITE.
REQ-022 WRITE lasts exactly one cycle: write_en=1, addr=BASE_ADDR+index, instr_in={hi,lo}; index then increments.
REQ-023 WRITE exit: when index+1 == N -> CHECK or DONE (per REQ-020); otherwise -> DAT_LO.
REQ-024 Outside WRITE: write_en=0, and addr and instr_in hold their last values.
REQ-025 Bytes presented while byte_ready is low are not consumed; the loader never drops or duplicates a byte.
REQ-026 busy is high in every state except IDLE, DONE and ERROR.
REQ-027 start asserted while busy is ignored.
REQ-028 Minimum cost is 3 cycles per word with continuous byte_valid.
REQ-029 Index and address arithmetic is 16-bit unsigned; N=DEPTH is legal, and the last write goes to BASE_ADDR+DEPTH-1.

Reset
REQ-030 rst asynchronously forces: state=IDLE, write_en=0, addr=0, instr_in=0, byte_ready=0, busy=0, done=0, error=0, cpu_hold=1, index=0, checksum=0.
REQ-031 rst asserted mid-load aborts the load immediately; no further write_en pulse occurs, and words already written are not rolled back.

Configuration
REQ-032 Macro LOADER_CHECKSUM_EN, when defined: an 8-bit checksum accumulates the modulo-256 sum of all data bytes (the count bytes are excluded); after the last word the FSM enters CHECK and accepts one byte; a match goes to DONE, a mismatch goes to ERROR.
REQ-033 When LOADER_CHECKSUM_EN is undefined: the CHECK state and the checksum register are absent, and the FSM goes directly from the last WRITE to DONE.

Verification
REQ-034 Reset, then start; stream 02 00 26 00 01 01 -> writes addr0=0x0026 and addr1=0x0101; done=1, cpu_hold=0.
REQ-035 Count bytes B5 00 (N=181) followed by 362 bytes -> final write at addr 180 (0xB4), then done=1; count B6 00 (N=182) -> error=1 and no write_en pulse.
REQ-036 byte_valid toggled randomly during a 3-word load -> exactly 3 write_en pulses with correct data, and no byte lost.
REQ-037 rst pulsed after the first word of a 4-word load -> all outputs take their reset values, and no further writes occur.
REQ-038 With LOADER_CHECKSUM_EN: stream 01 00 FE 00 then checksum FE -> done=1; checksum FF -> error=1 (the write to addr0 has already occurred).
REQ-039 Count bytes 00 00 -> no writes; done=1 (with LOADER_CHECKSUM_EN, after checksum byte 00).
